// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable burst of pulses on a_out.
//
// A burst is requested with `start` while idle. The configuration (high
// time, low time, pulse count) is captured in that same cycle and held for
// the whole burst. Every output is a flop whose next value is decoded from
// the next FSM state, so a_out, rose_strobe, busy, done and pulse_cnt all
// change together on the same clock edge.
//
// Optional build macro: PULSE_TRAIN_GEN_SVA_EN
//   When defined, a protocol checker (pulse_train_gen_sva) is bound into the
//   generator. Without it the generator logic is exactly the same.

module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             a_out,
    output logic             rose_strobe,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Phase lengths are stored as "cycles minus one" so the timer can count
    // down to zero. A programmed length of 0 behaves like 1, which maps to a
    // reload of 0 as well. The largest length (all ones) reloads with
    // all-ones minus one, so the timer never overflows.
    function automatic logic [CNT_W-1:0] len_to_reload(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] reload;
        if (len == {CNT_W{1'b0}}) begin
            reload = {CNT_W{1'b0}};
        end else begin
            reload = len - CNT_W'(1);
        end
        return reload;
    endfunction

    // Registered state
    state_t           state_r;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] high_m1_r;
    logic [CNT_W-1:0] low_m1_r;
    logic [NUM_W-1:0] num_r;
    logic [NUM_W-1:0] cnt_r;
    logic             a_out_r;
    logic             rose_r;
    logic             busy_r;
    logic             done_r;

    // Next-state values
    state_t           state_s;
    logic [CNT_W-1:0] timer_s;
    logic [CNT_W-1:0] high_m1_s;
    logic [CNT_W-1:0] low_m1_s;
    logic [NUM_W-1:0] num_s;
    logic [NUM_W-1:0] cnt_s;
    logic             rose_s;

    // Next-state and next-count decode for the burst sequencer.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        high_m1_s = high_m1_r;
        low_m1_s  = low_m1_r;
        num_s     = num_r;
        cnt_s     = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    high_m1_s = len_to_reload(high_len);
                    low_m1_s  = len_to_reload(low_len);
                    num_s     = num_pulses;
                    if (num_pulses != {NUM_W{1'b0}}) begin
                        // First rising edge is emitted in the very next cycle
                        // and counted there.
                        state_s = ST_HIGH;
                        timer_s = len_to_reload(high_len);
                        cnt_s   = NUM_W'(1);
                    end else begin
                        // Empty burst: straight to the done cycle, no edge.
                        state_s = ST_DONE;
                        timer_s = {CNT_W{1'b0}};
                        cnt_s   = {NUM_W{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HIGH: begin
                if (timer_r == {CNT_W{1'b0}}) begin
                    if (cnt_r == num_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOW;
                        timer_s = low_m1_r;
                    end
                end else begin
                    timer_s = timer_r - CNT_W'(1);
                end
            end

            ST_LOW: begin
                if (timer_r == {CNT_W{1'b0}}) begin
                    state_s = ST_HIGH;
                    timer_s = high_m1_r;
                    cnt_s   = cnt_r + NUM_W'(1);
                end else begin
                    timer_s = timer_r - CNT_W'(1);
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                timer_s = {CNT_W{1'b0}};
            end
        endcase

        // A rising edge on a_out is exactly an entry into HIGH.
        if ((state_s == ST_HIGH) && (state_r != ST_HIGH)) begin
            rose_s = 1'b1;
        end else begin
            rose_s = 1'b0;
        end
    end

    // State, configuration and output registers; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {CNT_W{1'b0}};
            high_m1_r <= {CNT_W{1'b0}};
            low_m1_r  <= {CNT_W{1'b0}};
            num_r     <= {NUM_W{1'b0}};
            cnt_r     <= {NUM_W{1'b0}};
            a_out_r   <= 1'b0;
            rose_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            high_m1_r <= high_m1_s;
            low_m1_r  <= low_m1_s;
            num_r     <= num_s;
            cnt_r     <= cnt_s;
            a_out_r   <= (state_s == ST_HIGH);
            rose_r    <= rose_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign a_out       = a_out_r;
    assign rose_strobe = rose_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pulse_cnt   = cnt_r;

`ifdef PULSE_TRAIN_GEN_SVA_EN
    pulse_train_gen_sva u_sva (
        .clk         (clk),
        .rst         (rst),
        .a_out       (a_out_r),
        .rose_strobe (rose_r),
        .busy        (busy_r),
        .done        (done_r)
    );
`else
    // No protocol checker in this build.
`endif

endmodule

`ifdef PULSE_TRAIN_GEN_SVA_EN
// Protocol checker for the generator outputs, observing only the ports.
module pulse_train_gen_sva (
    input logic clk,
    input logic rst,
    input logic a_out,
    input logic rose_strobe,
    input logic busy,
    input logic done
);

    a_rose_matches_strobe: assert property (
        @(posedge clk) disable iff (rst) ($rose(a_out) == rose_strobe)
    ) else $error("pulse_train_gen: rose_strobe disagrees with a_out edge at %0t", $time);

    a_done_quiet_busy: assert property (
        @(posedge clk) disable iff (rst) done |-> (!a_out && busy)
    ) else $error("pulse_train_gen: done without busy or with a_out high at %0t", $time);

    a_done_then_idle: assert property (
        @(posedge clk) disable iff (rst) done |=> !busy
    ) else $error("pulse_train_gen: busy still high after done at %0t", $time);

    a_strobe_single: assert property (
        @(posedge clk) disable iff (rst) rose_strobe |=> !rose_strobe
    ) else $error("pulse_train_gen: rose_strobe longer than one cycle at %0t", $time);

    a_busy_entry: assert property (
        @(posedge clk) disable iff (rst) $rose(busy) |-> (rose_strobe || done)
    ) else $error("pulse_train_gen: busy rose without edge or done at %0t", $time);

endmodule
`endif

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen. A waveform model expands each
// accepted burst into the list of per-cycle output values it must produce;
// every cycle the DUT outputs are compared against the head of that list.
// Directed traces additionally pin literal waveforms.

module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] num_pulses;
    logic       a_out;
    logic       rose_strobe;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    always #5 clk = ~clk;

    pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .high_len    (high_len),
        .low_len     (low_len),
        .num_pulses  (num_pulses),
        .a_out       (a_out),
        .rose_strobe (rose_strobe),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    typedef struct packed {
        logic       a;
        logic       r;
        logic       b;
        logic       d;
        logic [7:0] c;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] idle_cnt;
    int         tests = 0;
    int         fails = 0;

    logic [31:0] a_tr, r_tr, d_tr, b_tr;
    logic [7:0]  cnt_tr [0:31];
    int          cyc;

    // Expand one accepted burst into its full list of cycles.
    task automatic build(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        int   hh;
        int   ll;
        exp_t e;
        hh = (h == 8'd0) ? 1 : int'(h);
        ll = (l == 8'd0) ? 1 : int'(l);
        for (int p = 1; p <= int'(n); p++) begin
            for (int c = 0; c < hh; c++) begin
                e.a = 1'b1; e.r = (c == 0); e.b = 1'b1; e.d = 1'b0; e.c = 8'(p);
                exp_q.push_back(e);
            end
            if (p < int'(n)) begin
                for (int c = 0; c < ll; c++) begin
                    e.a = 1'b0; e.r = 1'b0; e.b = 1'b1; e.d = 1'b0; e.c = 8'(p);
                    exp_q.push_back(e);
                end
            end
        end
        e.a = 1'b0; e.r = 1'b0; e.b = 1'b1; e.d = 1'b1; e.c = n;
        exp_q.push_back(e);
        idle_cnt = n;
    endtask

    // Model reaction to one clock edge.
    task automatic model_edge();
        if (rst) begin
            exp_q.delete();
            idle_cnt = 8'd0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (start) begin
            build(high_len, low_len, num_pulses);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock: update model at the edge, compare at the falling edge.
    task automatic step();
        exp_t e;
        exp_t act;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
        end else begin
            e = {4'b0000, idle_cnt};
        end
        act = {a_out, rose_strobe, busy, done, pulse_cnt};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL cycle_check t=%0t a/rose/busy/done/cnt got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     $time, act.a, act.r, act.b, act.d, act.c, e.a, e.r, e.b, e.d, e.c);
        end
        if (cyc < 32) begin
            a_tr[cyc]   = a_out;
            r_tr[cyc]   = rose_strobe;
            d_tr[cyc]   = done;
            b_tr[cyc]   = busy;
            cnt_tr[cyc] = pulse_cnt;
        end
        cyc++;
    endtask

    // Start a burst at edge 0, optionally reset or re-pulse start later.
    task automatic run_trace(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                             input int rst_cyc, input int re_cyc, input int re_len,
                             input logic [7:0] h2, input logic [7:0] l2, input logic [7:0] n2,
                             input int ncyc);
        a_tr = 32'd0; r_tr = 32'd0; d_tr = 32'd0; b_tr = 32'd0;
        for (int k = 0; k < 32; k++) cnt_tr[k] = 8'd0;
        cyc = 1;
        for (int i = 0; i < ncyc; i++) begin
            rst = (i == rst_cyc);
            if (i == 0) begin
                start = 1'b1; high_len = h; low_len = l; num_pulses = n;
            end else if (re_cyc >= 0 && i >= re_cyc && i < re_cyc + re_len) begin
                start = 1'b1; high_len = h2; low_len = l2; num_pulses = n2;
            end else begin
                start = 1'b0;
                high_len = 8'($urandom); low_len = 8'($urandom); num_pulses = 8'($urandom);
            end
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        cyc = 32;
        idle_cnt = 8'd0;
        rst = 1'b1; start = 1'b0;
        high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_state", {27'd0, a_out, rose_strobe, busy, done, 1'b0} | {24'd0, pulse_cnt}, 32'd0);

        // Reset in the middle of a H=2 L=2 N=5 burst (rst high in cycle 6).
        run_trace(8'd2, 8'd2, 8'd5, 6, -1, 0, 8'd0, 8'd0, 8'd0, 12);
        chk("rst_mid_a",     a_tr, 32'h66);
        chk("rst_mid_busy",  b_tr, 32'h7E);
        chk("rst_mid_done",  d_tr, 32'h0);
        chk("rst_mid_cnt6",  {24'd0, cnt_tr[6]}, 32'd2);
        chk("rst_mid_cnt7",  {24'd0, cnt_tr[7]}, 32'd0);

        // Basic H=1 L=1 N=3.
        run_trace(8'd1, 8'd1, 8'd3, -1, -1, 0, 8'd0, 8'd0, 8'd0, 8);
        chk("basic_a",    a_tr, 32'h2A);
        chk("basic_rose", r_tr, 32'h2A);
        chk("basic_done", d_tr, 32'h40);
        chk("basic_cnt",  {24'd0, cnt_tr[8]}, 32'd3);

        // Zero lengths behave like 1.
        run_trace(8'd0, 8'd0, 8'd2, -1, -1, 0, 8'd0, 8'd0, 8'd0, 6);
        chk("zero_len_a",    a_tr, 32'h0A);
        chk("zero_len_done", d_tr, 32'h10);
        chk("zero_len_cnt",  {24'd0, cnt_tr[4]}, 32'd2);

        // Empty burst.
        run_trace(8'd5, 8'd5, 8'd0, -1, -1, 0, 8'd0, 8'd0, 8'd0, 4);
        chk("empty_a",    a_tr, 32'h0);
        chk("empty_rose", r_tr, 32'h0);
        chk("empty_done", d_tr, 32'h2);
        chk("empty_busy", b_tr, 32'h2);
        chk("empty_cnt",  {24'd0, cnt_tr[1]}, 32'd0);

        // Start pulsed while busy is ignored.
        run_trace(8'd3, 8'd2, 8'd2, -1, 2, 1, 8'd3, 8'd2, 8'd7, 12);
        chk("busy_start_a",    a_tr, 32'h1CE);
        chk("busy_start_done", d_tr, 32'h200);
        chk("busy_start_cnt",  {24'd0, cnt_tr[11]}, 32'd2);

        // Start held through the done cycle (ignored) and the next idle cycle (accepted).
        run_trace(8'd2, 8'd1, 8'd1, -1, 3, 2, 8'd4, 8'd1, 8'd1, 12);
        chk("b2b_a",    a_tr, 32'h1E6);
        chk("b2b_rose", r_tr, 32'h22);
        chk("b2b_done", d_tr, 32'h208);
        chk("b2b_busy", b_tr, 32'h3EE);
        chk("b2b_cnt",  {24'd0, cnt_tr[9]}, 32'd1);

        // Maximum high time.
        run_trace(8'd255, 8'd0, 8'd2, -1, -1, 0, 8'd0, 8'd0, 8'd0, 520);
        chk("max_len_a", a_tr, 32'hFFFF_FFFE);

        // Randomized traffic against the model.
        cyc = 32;
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                high_len = 8'($urandom_range(0, 40));
            end else begin
                high_len = 8'($urandom_range(0, 4));
            end
            low_len    = 8'($urandom_range(0, 4));
            num_pulses = 8'($urandom_range(0, 5));
            step();
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
